// File: rtl/mux_2_1_hls_deadlock_pkg.sv
// Shared types and default constants for the HLS deadlock detector.
// The rpt_time payload field exists only when MUX_2_1_DEADLOCK_TIMESTAMP_EN is defined.
package mux_2_1_hls_deadlock_pkg;

    localparam int DEF_NUM_AXIS  = 3;
    localparam int DEF_THRESHOLD = 1024;
    localparam int DEF_CNT_W     = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        REPORT = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // Report payload layout for the default configuration.
    typedef struct packed {
        logic [DEF_NUM_AXIS-1:0] mask;
        logic [DEF_CNT_W-1:0]    cycles;
`ifdef MUX_2_1_DEADLOCK_TIMESTAMP_EN
        logic [31:0]             stamp;
`endif
    } report_t;

endpackage

// File: rtl/mux_2_1_hls_deadlock_sustain_cnt.sv
// Saturating counter of consecutive cycles with block high.
// hit flags the cycle whose sampled block brings the count to THRESHOLD.
module mux_2_1_hls_deadlock_sustain_cnt
    import mux_2_1_hls_deadlock_pkg::*;
#(
    parameter int THRESHOLD = DEF_THRESHOLD,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic clock,
    input  logic reset,
    input  logic block,
    input  logic restart,
    output logic hit
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(THRESHOLD - 1);
    localparam logic [CNT_W-1:0] SAT  = CNT_W'(THRESHOLD);

    logic [CNT_W-1:0] count;

    assign hit = block && (count == LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (restart || !block) begin
            count <= '0;
        end else if (count != SAT) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mux_2_1_hls_deadlock_detector.sv
// Qualifies a sustained monitor block into a one-shot deadlock report and sticky flag.
// Define MUX_2_1_DEADLOCK_TIMESTAMP_EN to add the rpt_time capture of a free-running cycle counter.
module mux_2_1_hls_deadlock_detector
    import mux_2_1_hls_deadlock_pkg::*;
#(
    parameter int NUM_AXIS  = DEF_NUM_AXIS,
    parameter int THRESHOLD = DEF_THRESHOLD,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                block,
    input  logic [NUM_AXIS-1:0] axis_block_sigs,
    input  logic                clear,
    output logic                rpt_valid,
    input  logic                rpt_ready,
    output logic [NUM_AXIS-1:0] rpt_mask,
    output logic [CNT_W-1:0]    rpt_cycles,
    output logic                deadlock
`ifdef MUX_2_1_DEADLOCK_TIMESTAMP_EN
    ,
    output logic [31:0]         rpt_time
`endif
);

    typedef struct packed {
        logic [NUM_AXIS-1:0] mask;
        logic [CNT_W-1:0]    cycles;
`ifdef MUX_2_1_DEADLOCK_TIMESTAMP_EN
        logic [31:0]         stamp;
`endif
    } payload_t;

    state_t   state_q, state_d;
    payload_t payload_q, payload_d;
    logic     valid_q, valid_d;
    logic     dead_q, dead_d;
    logic     restart;
    logic     hit;

`ifdef MUX_2_1_DEADLOCK_TIMESTAMP_EN
    logic [31:0] stamp_q;

    // Free-running; wraps naturally and is deliberately untouched by clear.
    always_ff @(posedge clock) begin
        if (reset) stamp_q <= '0;
        else       stamp_q <= stamp_q + 32'd1;
    end
`endif

    mux_2_1_hls_deadlock_sustain_cnt #(
        .THRESHOLD (THRESHOLD),
        .CNT_W     (CNT_W)
    ) u_sustain (
        .clock   (clock),
        .reset   (reset),
        .block   (block),
        .restart (restart),
        .hit     (hit)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        payload_d = payload_q;
        valid_d   = valid_q;
        dead_d    = dead_q;
        restart   = 1'b0;
        unique case (state_q)
            IDLE, COUNT: begin
                if (clear) begin
                    restart = 1'b1;
                    state_d = IDLE;
                end else if (hit) begin
                    state_d          = REPORT;
                    payload_d.mask   = axis_block_sigs;
                    payload_d.cycles = CNT_W'(THRESHOLD);
`ifdef MUX_2_1_DEADLOCK_TIMESTAMP_EN
                    payload_d.stamp  = stamp_q;
`endif
                    valid_d          = 1'b1;
                    dead_d           = 1'b1;
                end else begin
                    state_d = block ? COUNT : IDLE;
                end
            end
            // clear is ignored here so a pending report is never lost.
            REPORT: begin
                if (rpt_ready) begin
                    state_d = HOLD;
                    valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (clear) begin
                    restart   = 1'b1;
                    state_d   = IDLE;
                    payload_d = '0;
                    dead_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            payload_q <= '0;
            valid_q   <= 1'b0;
            dead_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            payload_q <= payload_d;
            valid_q   <= valid_d;
            dead_q    <= dead_d;
        end
    end

    assign rpt_valid  = valid_q;
    assign rpt_mask   = payload_q.mask;
    assign rpt_cycles = payload_q.cycles;
    assign deadlock   = dead_q;
`ifdef MUX_2_1_DEADLOCK_TIMESTAMP_EN
    assign rpt_time   = payload_q.stamp;
`endif

endmodule

// File: tb/tb_mux_2_1_hls_deadlock_detector.sv
// Directed table-driven bench for the deadlock detector (THRESHOLD=4 and THRESHOLD=1 instances).
// Inputs change 1ns after a rising edge; outputs are sampled 1ns after the next edge.
module tb_mux_2_1_hls_deadlock_detector;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        block = 1'b0;
    logic [2:0]  axis_block_sigs = 3'b000;
    logic        clear = 1'b0;
    logic        rpt_ready = 1'b0;

    logic        v4, d4, v1, d1;
    logic [2:0]  m4, m1;
    logic [15:0] c4, c1;
`ifdef MUX_2_1_DEADLOCK_TIMESTAMP_EN
    logic [31:0] t4, t1;
`endif

    always #5 clock = ~clock;

    mux_2_1_hls_deadlock_detector #(.NUM_AXIS(3), .THRESHOLD(4), .CNT_W(16)) dut4 (
        .clock           (clock),
        .reset           (reset),
        .block           (block),
        .axis_block_sigs (axis_block_sigs),
        .clear           (clear),
        .rpt_valid       (v4),
        .rpt_ready       (rpt_ready),
        .rpt_mask        (m4),
        .rpt_cycles      (c4),
        .deadlock        (d4)
`ifdef MUX_2_1_DEADLOCK_TIMESTAMP_EN
        ,
        .rpt_time        (t4)
`endif
    );

    mux_2_1_hls_deadlock_detector #(.NUM_AXIS(3), .THRESHOLD(1), .CNT_W(16)) dut1 (
        .clock           (clock),
        .reset           (reset),
        .block           (block),
        .axis_block_sigs (axis_block_sigs),
        .clear           (clear),
        .rpt_valid       (v1),
        .rpt_ready       (rpt_ready),
        .rpt_mask        (m1),
        .rpt_cycles      (c1),
        .deadlock        (d1)
`ifdef MUX_2_1_DEADLOCK_TIMESTAMP_EN
        ,
        .rpt_time        (t1)
`endif
    );

    typedef struct {
        logic        blk;
        logic [2:0]  ax;
        logic        clr;
        logic        rdy;
        logic        ev;
        logic [2:0]  em;
        logic [15:0] ec;
        logic        ed;
    } vec_t;

    localparam int NVEC = 33;
    vec_t vecs [NVEC];

    int n_vec  = 0;
    int n_miss = 0;

    function automatic vec_t mk(input logic blk, input logic [2:0] ax, input logic clr,
                                input logic rdy, input logic ev, input logic [2:0] em,
                                input logic [15:0] ec, input logic ed);
        vec_t r;
        r.blk = blk; r.ax = ax; r.clr = clr; r.rdy = rdy;
        r.ev = ev; r.em = em; r.ec = ec; r.ed = ed;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check4(input string tag, input logic ev, input logic [2:0] em,
                          input logic [15:0] ec, input logic ed);
        check($sformatf("%s rpt_valid", tag),  32'(v4), 32'(ev));
        check($sformatf("%s rpt_mask", tag),   32'(m4), 32'(em));
        check($sformatf("%s rpt_cycles", tag), 32'(c4), 32'(ec));
        check($sformatf("%s deadlock", tag),   32'(d4), 32'(ed));
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Runs of 3 then 4 blocked cycles; only the second run reports.
        vecs[0]  = mk(0, 3'b000, 0, 0, 0, 3'b000, 0, 0);
        vecs[1]  = mk(1, 3'b010, 0, 0, 0, 3'b000, 0, 0);
        vecs[2]  = mk(1, 3'b010, 0, 0, 0, 3'b000, 0, 0);
        vecs[3]  = mk(1, 3'b010, 0, 0, 0, 3'b000, 0, 0);
        vecs[4]  = mk(0, 3'b010, 0, 0, 0, 3'b000, 0, 0);
        vecs[5]  = mk(1, 3'b010, 0, 0, 0, 3'b000, 0, 0);
        vecs[6]  = mk(1, 3'b010, 0, 0, 0, 3'b000, 0, 0);
        vecs[7]  = mk(1, 3'b010, 0, 0, 0, 3'b000, 0, 0);
        vecs[8]  = mk(1, 3'b010, 0, 0, 1, 3'b010, 4, 1);
        // Ten cycles of backpressure with toggling mask, clear pulses ignored.
        vecs[9]  = mk(1, 3'b101, 0, 0, 1, 3'b010, 4, 1);
        vecs[10] = mk(0, 3'b111, 0, 0, 1, 3'b010, 4, 1);
        vecs[11] = mk(1, 3'b000, 0, 0, 1, 3'b010, 4, 1);
        vecs[12] = mk(1, 3'b101, 1, 0, 1, 3'b010, 4, 1);
        vecs[13] = mk(0, 3'b010, 0, 0, 1, 3'b010, 4, 1);
        vecs[14] = mk(1, 3'b111, 0, 0, 1, 3'b010, 4, 1);
        vecs[15] = mk(0, 3'b001, 0, 0, 1, 3'b010, 4, 1);
        vecs[16] = mk(1, 3'b100, 1, 0, 1, 3'b010, 4, 1);
        vecs[17] = mk(0, 3'b011, 0, 0, 1, 3'b010, 4, 1);
        vecs[18] = mk(1, 3'b101, 0, 0, 1, 3'b010, 4, 1);
        // Handshake, HOLD ignores block, clear re-arms.
        vecs[19] = mk(1, 3'b101, 0, 1, 0, 3'b010, 4, 1);
        vecs[20] = mk(1, 3'b111, 0, 0, 0, 3'b010, 4, 1);
        vecs[21] = mk(0, 3'b000, 1, 0, 0, 3'b000, 0, 0);
        vecs[22] = mk(1, 3'b101, 0, 0, 0, 3'b000, 0, 0);
        vecs[23] = mk(1, 3'b101, 0, 0, 0, 3'b000, 0, 0);
        vecs[24] = mk(1, 3'b101, 0, 0, 0, 3'b000, 0, 0);
        vecs[25] = mk(1, 3'b101, 0, 0, 1, 3'b101, 4, 1);
        // Handshake with simultaneous clear: handshake wins, clear dropped.
        vecs[26] = mk(1, 3'b011, 1, 1, 0, 3'b101, 4, 1);
        vecs[27] = mk(0, 3'b000, 1, 0, 0, 3'b000, 0, 0);
        // clear in IDLE with block high restarts the count.
        vecs[28] = mk(1, 3'b110, 1, 0, 0, 3'b000, 0, 0);
        vecs[29] = mk(1, 3'b110, 0, 0, 0, 3'b000, 0, 0);
        vecs[30] = mk(1, 3'b110, 0, 0, 0, 3'b000, 0, 0);
        vecs[31] = mk(1, 3'b110, 0, 0, 0, 3'b000, 0, 0);
        vecs[32] = mk(1, 3'b110, 0, 0, 1, 3'b110, 4, 1);

        reset = 1'b1;
        repeat (3) step();
        check4("reset", 0, 3'b000, 16'd0, 0);
        check("reset t1 rpt_valid", 32'(v1), 32'd0);
        check("reset t1 deadlock", 32'(d1), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            block           = vecs[i].blk;
            axis_block_sigs = vecs[i].ax;
            clear           = vecs[i].clr;
            rpt_ready       = vecs[i].rdy;
            step();
            check4($sformatf("vec%0d", i), vecs[i].ev, vecs[i].em, vecs[i].ec, vecs[i].ed);
        end

        // Reset while a report is pending drops it.
        block = 1'b0; clear = 1'b0; rpt_ready = 1'b0; axis_block_sigs = 3'b000;
        reset = 1'b1;
        step();
        check4("reset mid report", 0, 3'b000, 16'd0, 0);
        check("reset mid report t1 deadlock", 32'(d1), 32'd0);
        reset = 1'b0;
        step();
        check("t1 idle rpt_valid", 32'(v1), 32'd0);

        // THRESHOLD=1 reports on the first sampled block.
        block = 1'b1; axis_block_sigs = 3'b110;
        step();
        check("t1 rpt_valid", 32'(v1), 32'd1);
        check("t1 rpt_mask", 32'(m1), 32'b110);
        check("t1 rpt_cycles", 32'(c1), 32'd1);
        check("t1 deadlock", 32'(d1), 32'd1);
        check4("t4 after reset 1", 0, 3'b000, 16'd0, 0);
        step();
        step();
        check("t4 after reset 3 rpt_valid", 32'(v4), 32'd0);
        step();
        check4("t4 after reset 4", 1, 3'b110, 16'd4, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
